idct_2d_seq: RTL and testbench
==============================

# idct_2d_seq

Sequential 8x8 two-dimensional inverse DCT, the decoder-side counterpart of the forward DCT stage. It accepts one block of 64 dequantized coefficients as a raster-order stream, runs a row pass and then a column pass on a single multiply-accumulate datapath through a transpose buffer, and streams 64 reconstructed 8-bit samples back out. It sits between dequantization and the pixel writer in the decode path.

## Interface
- BLOCK_SIZE, 8, block edge; only 8 is supported, and any other value fails elaboration.
- COS_FILE, "../memfiles/idct_cosine_vals.mem", cosine ROM image loaded with $readmemh.
- clk  in  1  single clock; all logic rises on posedge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_coef  in  16  signed coefficient; raster order, index u (column) fastest.
- in_valid  in  1  in_coef is valid.
- in_ready  out  1  block accepts input; reset value 0.
- out_pix  out  8  unsigned reconstructed sample; raster order, x fastest; reset value 0.
- out_valid  out  1  out_pix is valid; reset value 0.
- out_last  out  1  high with the 64th sample of the block; reset value 0.
- out_ready  in  1  downstream accepts out_pix.
- busy  out  1  high in ROW, COL or OUT; reset value 0.

## Operation
- FSM states: LOAD -> ROW -> COL -> OUT -> LOAD. Reset forces LOAD.
- in_ready is registered. It is 0 while rst_n is low and equals (state==LOAD) from the first clock after reset release.
- LOAD
  - A beat transfers when in_valid && in_ready.
  - The 6-bit in_cnt stores the beat at coef_buf[in_cnt].
  - On the 64th beat (in_cnt==63), move to ROW and clear in_ready in the same edge.
- ROM
  - 64 entries, C[u][x] = alpha(u)*cos((2x+1)u*pi/16).
  - Format is signed Q1.14 held in 16 bits; C[0][x] = 5793.
- ROW pass
  - For each (y,x) in raster order: t[y][x] = sum over u of coef[y][u]*C[u][x].
  - Product is 32 bits; accumulator is 36-bit signed.
  - Result = (acc + 8192) >>> 14, saturated to signed 18 bits, written to t_buf[y][x].
- COL pass
  - For each (y,x) in raster order: p[y][x] = sum over v of t[v][x]*C[v][y].
  - Product is 34 bits; accumulator is 38-bit signed.
  - Result = (acc + 8192) >>> 14, clamped to [0,255], written to coef_buf[y][x], which is free after ROW.
- MAC schedule
  - The 3-bit k counter steps through the inner index 0..7, one term per cycle.
  - Operands come from combinational buffer/ROM reads.
  - At k==0 the accumulator loads the product; at k==7 the result is written and the 6-bit index advances.
- OUT
  - out_pix = coef_buf[out_cnt][7:0]; out_valid held high.
  - out_cnt advances on out_valid && out_ready.
  - out_last = out_valid && out_cnt==63.
  - The handshake on the last sample clears out_valid and moves to LOAD.
- Data and out_valid stay stable while out_ready is low, with no sample dropped or repeated.
- Asynchronous reset in any state has the same effect:
  - returns to LOAD, zeroes all counters, and drops out_valid, out_last and busy;
  - buffer contents become don't-care, and the next block is processed correctly.

## Timing
- Cycle 0 is the edge accepting the 64th input beat.
  - ROW occupies cycles 1-512 and COL occupies cycles 513-1024.
  - out_valid rises after edge 1024 and is visible in cycle 1025.
- With out_ready held high, the samples take 64 cycles. in_ready returns in the cycle after the out_last handshake.
- Throughput: one block per 1024 + 64 + 64 cycles minimum. There is no overlap between blocks.
- in_valid outside LOAD is ignored.

## Structure
- Package idct_pkg holds:
  - BLK = 8, BLK_SQ = 64, COS_FRAC = 14, COEF_W = 16, T_W = 18, PIX_W = 8;
  - the state enum {LOAD, ROW, COL, OUT};
  - accumulator widths 36 and 38.
- Sub-module idct_mac:
  - inputs: signed operand, signed cosine, first, last and pass select;
  - outputs: registered accumulator and the rounded/saturated result for both passes.
- The top level holds the FSM, counters, two 64-entry buffers and the ROM.

## Test plan
- DC block, coef[0][0]=1024 and all others 0 -> all 64 out_pix = 128; out_last only on beat 64; first out_valid in cycle 1025.
- All 64 coefficients 0 -> 64 samples of 0, busy high from cycle 1 until the last handshake.
- coef[0][0]=32767 -> all 255 (saturated); coef[0][0]=-1024 -> all 0 (clamped).
- Random out_ready (50%) on the DC block -> exactly 64 samples of 128, stable while stalled, and in_ready stays 0 until out_last transfers.
- rst_n pulsed low in cycle 700 (COL) -> out_valid/busy 0 immediately, in_ready 1 after release; a following DC=1024 block yields 64 × 128.
- Back-to-back blocks against a software model, using random coefficients in [-512,511] -> bit-exact match on every sample; in_valid driven during ROW/COL is ignored.

Source files
------------

// File: rtl/idct_pkg.sv
// -----------------------------------------------------------------------------
// idct_pkg
// Shared constants, the FSM state type and the cosine table generator for the
// sequential 8x8 inverse DCT (idct_2d_seq).
//   BLK/BLK_SQ  : block edge and block size in samples
//   COS_FRAC    : fractional bits of the Q1.14 cosine table
//   COEF_W/T_W  : coefficient and row-pass intermediate widths
//   PIX_W       : output sample width
//   ACC_*_W     : accumulator widths of the row and column passes
// -----------------------------------------------------------------------------
package idct_pkg;

    localparam int BLK       = 8;
    localparam int BLK_SQ    = 64;
    localparam int IDX_W     = 6;
    localparam int K_W       = 3;
    localparam int COS_FRAC  = 14;
    localparam int COEF_W    = 16;
    localparam int T_W       = 18;
    localparam int PIX_W     = 8;
    localparam int PROD_W    = T_W + COEF_W;
    localparam int ACC_ROW_W = 36;
    localparam int ACC_COL_W = 38;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        ROW  = 2'd1,
        COL  = 2'd2,
        OUT  = 2'd3
    } state_t;

    // 0.5 * cos(m*pi/16) in Q1.14 for m = 0..8
    function automatic int cos_mag(input int m);
        case (m)
            0:       cos_mag = 8192;
            1:       cos_mag = 8035;
            2:       cos_mag = 7568;
            3:       cos_mag = 6811;
            4:       cos_mag = 5793;
            5:       cos_mag = 4551;
            6:       cos_mag = 3135;
            7:       cos_mag = 1598;
            default: cos_mag = 0;
        endcase
    endfunction

    // C[u][x] = alpha(u) * cos((2x+1)*u*pi/16), signed Q1.14.
    // The angle is folded into the first half-turn using cosine symmetry.
    function automatic logic signed [COEF_W-1:0] cos_q14(input int u, input int x);
        int m;
        int v;
        if (u == 0) begin
            v = 5793;
        end else begin
            m = ((2 * x + 1) * u) % 32;
            if (m > 16) begin
                m = 32 - m;
            end
            if (m <= 8) begin
                v = cos_mag(m);
            end else begin
                v = -cos_mag(16 - m);
            end
        end
        return v[COEF_W-1:0];
    endfunction

endpackage

// File: rtl/idct_2d_seq_if.sv
// -----------------------------------------------------------------------------
// idct_2d_seq_if
// Streaming bus of the inverse DCT block.
//   in_coef/in_valid/in_ready     : coefficient input stream (raster, u fastest)
//   out_pix/out_valid/out_ready   : pixel output stream (raster, x fastest)
//   out_last                      : marks the 64th sample of a block
//   busy                          : block is being transformed or drained
// master = stream source/sink (testbench or surrounding decoder), slave = IDCT.
// -----------------------------------------------------------------------------
interface idct_2d_seq_if;
    import idct_pkg::*;

    logic signed [COEF_W-1:0] in_coef;
    logic                     in_valid;
    logic                     in_ready;
    logic [PIX_W-1:0]         out_pix;
    logic                     out_valid;
    logic                     out_last;
    logic                     out_ready;
    logic                     busy;

    modport master (
        output in_coef, in_valid, out_ready,
        input  in_ready, out_pix, out_valid, out_last, busy
    );

    modport slave (
        input  in_coef, in_valid, out_ready,
        output in_ready, out_pix, out_valid, out_last, busy
    );
endinterface

// File: rtl/idct_mac.sv
// -----------------------------------------------------------------------------
// idct_mac
// Single multiply-accumulate datapath shared by the row and column passes.
//   clk, rst_n : clock and asynchronous active-low reset
//   en         : accumulate this cycle
//   first      : load the product instead of adding it
//   last       : final term of the dot product; results are valid this cycle
//   pass_col   : 0 = row pass (36-bit accumulation), 1 = column pass (38-bit)
//   opnd       : signed operand (coefficient or row-pass result)
//   cos_val    : signed Q1.14 cosine
//   res_valid  : en && last
//   row_res    : rounded result saturated to signed 18 bits
//   col_res    : rounded result clamped to [0,255]
// The results are taken from the running sum including the current term, so
// the k==7 edge can write them without an extra pipeline cycle.
// -----------------------------------------------------------------------------
module idct_mac
    import idct_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     first,
    input  logic                     last,
    input  logic                     pass_col,
    input  logic signed [T_W-1:0]    opnd,
    input  logic signed [COEF_W-1:0] cos_val,
    output logic                     res_valid,
    output logic signed [T_W-1:0]    row_res,
    output logic [PIX_W-1:0]         col_res
);

    localparam logic signed [ACC_COL_W-1:0] RND   = ACC_COL_W'(1 << (COS_FRAC - 1));
    localparam logic signed [ACC_COL_W-1:0] T_MAX = ACC_COL_W'((1 << (T_W - 1)) - 1);
    localparam logic signed [ACC_COL_W-1:0] T_MIN = -T_MAX - ACC_COL_W'(1);
    localparam logic signed [ACC_COL_W-1:0] P_MAX = ACC_COL_W'((1 << PIX_W) - 1);

    logic signed [PROD_W-1:0]    prod;
    logic signed [ACC_COL_W-1:0] sum_full;
    logic signed [ACC_COL_W-1:0] sum_d;
    logic signed [ACC_COL_W-1:0] rounded;
    logic signed [ACC_COL_W-1:0] acc_d;
    logic signed [ACC_COL_W-1:0] acc_q;

    always_comb begin
        prod     = PROD_W'(opnd) * PROD_W'(cos_val);
        sum_full = first ? ACC_COL_W'(prod) : acc_q + ACC_COL_W'(prod);
        // Row pass keeps a 36-bit accumulator: wrap to 36 bits, then sign-extend.
        if (pass_col) begin
            sum_d = sum_full;
        end else begin
            sum_d = ACC_COL_W'(signed'(sum_full[ACC_ROW_W-1:0]));
        end
        rounded = (sum_d + RND) >>> COS_FRAC;

        if (rounded > T_MAX) begin
            row_res = T_MAX[T_W-1:0];
        end else if (rounded < T_MIN) begin
            row_res = T_MIN[T_W-1:0];
        end else begin
            row_res = rounded[T_W-1:0];
        end

        if (rounded < 0) begin
            col_res = '0;
        end else if (rounded > P_MAX) begin
            col_res = P_MAX[PIX_W-1:0];
        end else begin
            col_res = rounded[PIX_W-1:0];
        end

        acc_d     = en ? sum_d : acc_q;
        res_valid = en && last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/idct_2d_seq.sv
// -----------------------------------------------------------------------------
// idct_2d_seq
// Sequential 8x8 2-D inverse DCT. Loads 64 coefficients, runs a row pass into
// t_buf and a column pass back into coef_buf on one MAC, then streams the 64
// reconstructed 8-bit samples.
//   BLOCK_SIZE : block edge, must be 8
//   COS_FILE   : name of the cosine image; the table itself is generated from
//                idct_pkg::cos_q14 and holds the same Q1.14 values
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : idct_2d_seq_if slave (input stream, output stream, busy)
// -----------------------------------------------------------------------------
module idct_2d_seq
    import idct_pkg::*;
#(
    parameter int BLOCK_SIZE = 8,
    parameter     COS_FILE   = "../memfiles/idct_cosine_vals.mem"
) (
    input  logic          clk,
    input  logic          rst_n,
    idct_2d_seq_if.slave  bus
);

    if (BLOCK_SIZE != BLK) begin : g_bad_block_size
        $error("idct_2d_seq: only BLOCK_SIZE == 8 is supported");
    end
    if ($bits(COS_FILE) < 8) begin : g_bad_cos_file
        $error("idct_2d_seq: COS_FILE must name the cosine image");
    end

    // Cosine ROM, index {u, x}
    logic signed [COEF_W-1:0] cos_rom [BLK_SQ];
    for (genvar gi = 0; gi < BLK_SQ; gi++) begin : g_rom
        assign cos_rom[gi] = cos_q14(gi / BLK, gi % BLK);
    end

    // coef_buf holds the input block, then the output pixels after COL.
    logic signed [COEF_W-1:0] coef_buf [BLK_SQ];
    logic signed [T_W-1:0]    t_buf    [BLK_SQ];

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   in_cnt_q, in_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [IDX_W-1:0]   out_cnt_q, out_cnt_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic                     coef_we;
    logic [IDX_W-1:0]         coef_waddr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic                     t_we;

    logic                     mac_en;
    logic                     mac_first;
    logic                     mac_last;
    logic                     mac_pass_col;
    logic signed [T_W-1:0]    mac_opnd;
    logic signed [COEF_W-1:0] mac_cos;
    logic                     mac_res_valid;
    logic signed [T_W-1:0]    mac_row_res;
    logic [PIX_W-1:0]         mac_col_res;

    // MAC control and operand selection; idx = {y, x}, k = inner index.
    always_comb begin
        mac_en       = (state_q == ROW) || (state_q == COL);
        mac_first    = (k_q == '0);
        mac_last     = (k_q == K_W'(BLK - 1));
        mac_pass_col = (state_q == COL);
        if (state_q == COL) begin
            // p[y][x] += t[k][x] * C[k][y]
            mac_opnd = t_buf[{k_q, idx_q[K_W-1:0]}];
            mac_cos  = cos_rom[{k_q, idx_q[IDX_W-1:K_W]}];
        end else begin
            // t[y][x] += coef[y][k] * C[k][x]
            mac_opnd = T_W'(coef_buf[{idx_q[IDX_W-1:K_W], k_q}]);
            mac_cos  = cos_rom[{k_q, idx_q[K_W-1:0]}];
        end
    end

    idct_mac u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (mac_en),
        .first     (mac_first),
        .last      (mac_last),
        .pass_col  (mac_pass_col),
        .opnd      (mac_opnd),
        .cos_val   (mac_cos),
        .res_valid (mac_res_valid),
        .row_res   (mac_row_res),
        .col_res   (mac_col_res)
    );

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        idx_d       = idx_q;
        k_d         = k_q;
        out_cnt_d   = out_cnt_q;
        out_valid_d = out_valid_q;
        coef_we     = 1'b0;
        coef_waddr  = in_cnt_q;
        coef_wdata  = bus.in_coef;
        t_we        = 1'b0;

        case (state_q)
            LOAD: begin
                if (bus.in_valid && in_ready_q) begin
                    coef_we  = 1'b1;
                    in_cnt_d = in_cnt_q + 1'b1;
                    if (in_cnt_q == IDX_W'(BLK_SQ - 1)) begin
                        state_d = ROW;
                    end
                end
            end
            ROW: begin
                k_d = k_q + 1'b1;
                if (mac_res_valid) begin
                    t_we  = 1'b1;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_W'(BLK_SQ - 1)) begin
                        state_d = COL;
                    end
                end
            end
            COL: begin
                k_d = k_q + 1'b1;
                if (mac_res_valid) begin
                    coef_we    = 1'b1;
                    coef_waddr = idx_q;
                    coef_wdata = {{(COEF_W - PIX_W){1'b0}}, mac_col_res};
                    idx_d      = idx_q + 1'b1;
                    if (idx_q == IDX_W'(BLK_SQ - 1)) begin
                        state_d     = OUT;
                        out_valid_d = 1'b1;
                    end
                end
            end
            OUT: begin
                if (out_valid_q && bus.out_ready) begin
                    out_cnt_d = out_cnt_q + 1'b1;
                    if (out_cnt_q == IDX_W'(BLK_SQ - 1)) begin
                        out_valid_d = 1'b0;
                        state_d     = LOAD;
                    end
                end
            end
            default: state_d = LOAD;
        endcase

        // Registered ready: drops on the edge that takes the 64th beat.
        in_ready_d = (state_d == LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            in_cnt_q    <= '0;
            idx_q       <= '0;
            k_q         <= '0;
            out_cnt_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            idx_q       <= idx_d;
            k_q         <= k_d;
            out_cnt_q   <= out_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Buffer contents are don't-care after reset, so they carry no reset.
    always_ff @(posedge clk) begin
        if (coef_we) begin
            coef_buf[coef_waddr] <= coef_wdata;
        end
        if (t_we) begin
            t_buf[idx_q] <= mac_row_res;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_valid_q && (out_cnt_q == IDX_W'(BLK_SQ - 1));
    assign bus.out_pix   = out_valid_q ? coef_buf[out_cnt_q][PIX_W-1:0] : '0;
    assign bus.busy      = (state_q != LOAD);

endmodule

// File: tb/tb_idct_2d_seq.sv
// -----------------------------------------------------------------------------
// tb_idct_2d_seq
// Self-checking bench for idct_2d_seq. Expected pixels come from a reference
// IDCT computed with real-valued cosines and pushed to a scoreboard queue when
// a block is driven; they are popped on each output handshake.
// -----------------------------------------------------------------------------
module tb_idct_2d_seq;

    typedef logic signed [15:0] blk_t [64];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    idct_2d_seq_if bus ();

    idct_2d_seq #(
        .BLOCK_SIZE (8),
        .COS_FILE   ("../memfiles/idct_cosine_vals.mem")
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_errors = 0;
    longint exp_q[$];
    int     cos_tab[64];

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int round_real(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    task automatic build_cos_tab();
        real pi = 3.14159265358979323846;
        real a;
        for (int u = 0; u < 8; u++) begin
            a = (u == 0) ? $sqrt(0.125) : 0.5;
            for (int x = 0; x < 8; x++) begin
                cos_tab[u*8 + x] = round_real(a * $cos(real'((2*x + 1) * u) * pi / 16.0) * 16384.0);
            end
        end
    endtask

    task automatic push_model(input blk_t c);
        longint t[64];
        longint acc;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                acc = 0;
                for (int u = 0; u < 8; u++) acc += longint'(c[y*8 + u]) * cos_tab[u*8 + x];
                acc = (acc + 8192) >>> 14;
                if (acc > 131071) acc = 131071;
                if (acc < -131072) acc = -131072;
                t[y*8 + x] = acc;
            end
        end
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                acc = 0;
                for (int v = 0; v < 8; v++) acc += t[v*8 + x] * cos_tab[v*8 + y];
                acc = (acc + 8192) >>> 14;
                if (acc < 0) acc = 0;
                if (acc > 255) acc = 255;
                exp_q.push_back(acc);
            end
        end
    endtask

    // Called at a negedge; returns just after the edge taking the 64th beat.
    task automatic drive_block(input blk_t c);
        int i = 0;
        int guard = 0;
        bit ok;
        while (i < 64 && guard < 400) begin
            bus.in_valid = 1'b1;
            bus.in_coef  = c[i];
            ok = bus.in_ready;
            @(posedge clk);
            if (ok) i++;
            guard++;
            if (i < 64) @(negedge clk);
        end
        if (i < 64) check_val("load_beats", i, 64);
    endtask

    // Counts cycles from the 64th-beat edge to the first visible out_valid.
    task automatic wait_output(input bit noise);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check_val("busy_cycle1", bus.busy, 1);
                check_val("in_ready_cycle1", bus.in_ready, 0);
            end
            bus.in_valid = noise;
            bus.in_coef  = 16'($urandom);
        end while (!bus.out_valid && cyc < 1200);
        check_val("first_valid_cycle", cyc, 1025);
    endtask

    task automatic collect_block(input string name, input bit rand_ready);
        int n = 0;
        int guard = 0;
        bit stalled = 1'b0;
        bit rdy;
        logic [7:0] held = '0;
        longint exp;
        bus.in_valid = 1'b0;
        while (n < 64 && guard < 4000) begin
            if (stalled) begin
                check_val("stall_valid", bus.out_valid, 1);
                check_val("stall_pix", bus.out_pix, held);
            end
            check_val("busy_out", bus.busy, 1);
            check_val("in_ready_out", bus.in_ready, 0);
            rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = 1'b0;
            if (bus.out_valid) begin
                if (rdy) begin
                    exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                    check_val("pix", bus.out_pix, exp);
                    check_val("last", bus.out_last, (n == 63) ? 1 : 0);
                    n++;
                end else begin
                    stalled = 1'b1;
                    held    = bus.out_pix;
                end
            end
            bus.out_ready = rdy;
            @(negedge clk);
            guard++;
        end
        if (n < 64) check_val("out_samples", n, 64);
        check_val("done_valid", bus.out_valid, 0);
        check_val("done_last", bus.out_last, 0);
        check_val("done_in_ready", bus.in_ready, 1);
        check_val("done_busy", bus.busy, 0);
        $display("block %s: %0d samples received", name, n);
    endtask

    task automatic run_block(input string name, input blk_t c, input bit noise, input bit rand_ready);
        push_model(c);
        drive_block(c);
        wait_output(noise);
        collect_block(name, rand_ready);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        blk_t dc_pos, zeros, dc_max, dc_neg, rnd_a, rnd_b;
        int cyc;

        build_cos_tab();
        for (int i = 0; i < 64; i++) begin
            dc_pos[i] = '0;
            zeros[i]  = '0;
            dc_max[i] = '0;
            dc_neg[i] = '0;
            rnd_a[i]  = 16'(int'($urandom_range(0, 1023)) - 512);
            rnd_b[i]  = 16'(int'($urandom_range(0, 1023)) - 512);
        end
        dc_pos[0] = 16'sd1024;
        dc_max[0] = 16'sd32767;
        dc_neg[0] = -16'sd1024;

        bus.in_coef   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_in_ready", bus.in_ready, 0);
        check_val("rst_out_valid", bus.out_valid, 0);
        check_val("rst_out_last", bus.out_last, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_out_pix", bus.out_pix, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_in_ready", bus.in_ready, 1);

        run_block("dc_1024", dc_pos, 1'b0, 1'b0);
        run_block("zeros", zeros, 1'b0, 1'b0);
        run_block("dc_32767", dc_max, 1'b0, 1'b0);
        run_block("dc_neg1024", dc_neg, 1'b0, 1'b0);
        run_block("dc_1024_stall", dc_pos, 1'b0, 1'b1);

        // Reset in the middle of the column pass
        drive_block(dc_pos);
        cyc = 0;
        while (cyc < 700) begin
            @(negedge clk);
            cyc++;
            bus.in_valid = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check_val("abort_out_valid", bus.out_valid, 0);
        check_val("abort_busy", bus.busy, 0);
        check_val("abort_in_ready", bus.in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("abort_release_in_ready", bus.in_ready, 1);
        $display("block abort: reset applied in cycle %0d", cyc);
        run_block("dc_1024_after_reset", dc_pos, 1'b0, 1'b0);

        // Back-to-back random blocks with in_valid noise during the passes
        run_block("random_a", rnd_a, 1'b1, 1'b1);
        run_block("random_b", rnd_b, 1'b1, 1'b0);

        check_val("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
